// File: rtl/fetch_decode_unit_if.sv
// Memory read handshake between the fetch/decode stage (master) and instruction memory (slave).
interface fetch_decode_unit_if;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage for the basic computer: PC, AR, IR, I flip-flop, one-hot opcode decode.
// Optional READ-state timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module fetch_decode_unit #(
  parameter logic [11:0] PC_RESET       = 12'h000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       start,
  input  logic                       exec_done,
  input  logic                       pc_load,
  input  logic [11:0]                pc_load_val,
  input  logic                       halt,
  fetch_decode_unit_if.master        mem,
  output logic [11:0]                pc,
  output logic [15:0]                ir_data,
  output logic                       i_flag,
  output logic [7:0]                 opcode_dec,
  output logic                       ir_valid,
  output logic                       sc_inr,
  output logic                       sc_clr,
  output logic                       fetch_err
);

  // The wait counter is 5 bits wide, so the limit must fit in 1..32.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..32");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_READ   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] pc_q;
  logic [11:0] ar_q;
  logic [15:0] ir_q;
  logic        i_q;
  logic        mem_req_q;
  logic        ir_valid_q;
  logic        rd_timeout;

  logic        ar_ld_pc;
  logic        ar_ld_ir;
  logic        ir_ld;
  logic        pc_ld_br;

  // State register; mem_req and ir_valid are registered decodes of the next state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= S_IDLE;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_req_q  <= (state_nxt == S_READ);
      ir_valid_q <= (state_nxt == S_EXEC);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_ADDR;
      S_ADDR:   state_nxt = S_READ;
      S_READ: begin
        if (mem.mem_ack)     state_nxt = S_DECODE;
        else if (rd_timeout) state_nxt = S_IDLE;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   if (exec_done) state_nxt = halt ? S_IDLE : S_ADDR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sc_inr   = 1'b0;
    sc_clr   = 1'b0;
    ar_ld_pc = 1'b0;
    ar_ld_ir = 1'b0;
    ir_ld    = 1'b0;
    pc_ld_br = 1'b0;
    unique case (state)
      S_IDLE:   sc_clr = 1'b1;
      S_ADDR: begin
        sc_inr   = 1'b1;
        ar_ld_pc = 1'b1;
      end
      S_READ: begin
        sc_inr = mem.mem_ack;
        ir_ld  = mem.mem_ack;
      end
      S_DECODE: begin
        sc_inr   = 1'b1;
        ar_ld_ir = 1'b1;
      end
      S_EXEC: begin
        sc_clr   = exec_done;
        pc_ld_br = exec_done & pc_load;
      end
      default: sc_clr = 1'b1;
    endcase
  end

  // Architectural registers: PC, AR, IR, I.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q <= PC_RESET;
      ar_q <= 12'h000;
      ir_q <= 16'h0000;
      i_q  <= 1'b0;
    end else begin
      if (ar_ld_pc)      ar_q <= pc_q;
      else if (ar_ld_ir) ar_q <= ir_q[11:0];
      if (ir_ld) begin
        ir_q <= mem.mem_rdata;
        pc_q <= pc_q + 12'd1;
      end else if (pc_ld_br) begin
        pc_q <= pc_load_val;
      end
      if (ar_ld_ir) i_q <= ir_q[15];
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] wait_cnt;
  logic       err_q;

  // Counter restarts from zero every time READ is entered.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wait_cnt <= 5'd0;
      err_q    <= 1'b0;
    end else begin
      if (state != S_READ)   wait_cnt <= 5'd0;
      else if (!mem.mem_ack) wait_cnt <= wait_cnt + 5'd1;
      if (rd_timeout)        err_q    <= 1'b1;
    end
  end

  assign rd_timeout = (state == S_READ) && !mem.mem_ack && (wait_cnt == WAIT_LAST);
  assign fetch_err  = err_q;
`else
  assign rd_timeout = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = ar_q;
  assign pc           = pc_q;
  assign ir_data      = ir_q;
  assign i_flag       = i_q;
  assign ir_valid     = ir_valid_q;
  assign opcode_dec   = 8'b0000_0001 << ir_q[14:12];

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Instruction fetch/decode stage directly upstream of the basic-computer control unit. Holds PC, AR, IR and the I flip-flop. Fetches one 16-bit instruction word from memory over a req/ack handshake, then decodes the opcode to one-hot D0–D7. Drives `sc_inr`/`sc_clr` and `ir_data` into the control unit, then waits for the execute phase to report completion before fetching the next word.

## Interface
Parameters:
- `PC_RESET`, 12'h000, PC value after reset.
- `TIMEOUT_CYCLES`, 16, READ-state wait limit; only used when `FETCH_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `clr_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  leave IDLE and begin fetching; ignored in any other state.
- `mem_rdata`  in  16  memory read data; sampled only when `mem_ack`=1 in READ.
- `mem_ack`  in  1  memory read complete.
- `exec_done`  in  1  control unit finished the current instruction.
- `pc_load`  in  1  branch request; honoured only with `exec_done`.
- `pc_load_val`  in  12  branch target.
- `halt`  in  1  sampled with `exec_done`; 1 returns the block to IDLE.
- `mem_req`  out  1  read request.
- `mem_addr`  out  12  read address (= AR).
- `pc`  out  12  current PC.
- `ir_data`  out  16  IR contents.
- `i_flag`  out  1  I flip-flop (IR[15], captured in DECODE).
- `opcode_dec`  out  8  one-hot decode of IR[14:12]; bit n = Dn.
- `ir_valid`  out  1  high throughout EXEC.
- `sc_inr`  out  1  sequence-counter increment.
- `sc_clr`  out  1  sequence-counter clear.
- `fetch_err`  out  1  sticky timeout flag; present only with `FETCH_TIMEOUT_EN`, otherwise tied 0.

## Operation
- States: IDLE, ADDR (T0), READ (T1), DECODE (T2), EXEC.
- IDLE:
  - `start` -> ADDR.
  - `sc_clr`=1 every IDLE cycle, so the counter is held at 0.
- ADDR:
  - AR<=PC, `sc_inr`=1, -> READ.
- READ:
  - `mem_req`=1, `mem_addr`=AR.
  - On `mem_ack`: IR<=`mem_rdata`, PC<=PC+1 (12-bit wrap, FFF->000), `sc_inr`=1, -> DECODE.
  - Without `mem_ack`: hold, `sc_inr`=0.
- DECODE:
  - I<=IR[15], AR<=IR[11:0], `sc_inr`=1, -> EXEC.
- EXEC:
  - `ir_valid`=1 and `sc_inr`=0; the control unit owns the counter.
  - On `exec_done`: `sc_clr`=1 for one cycle.
  - PC<=`pc_load_val` if `pc_load`=1.
  - Next state: IDLE if `halt`=1, else ADDR.
- `opcode_dec` is decoded combinationally from IR[14:12]; meaningful only while `ir_valid`=1.
- `sc_inr` and `sc_clr` are never high together.
- `pc_load` or `halt` without `exec_done`: ignored.
- `exec_done` outside EXEC: ignored.
- `mem_ack` outside READ: ignored; IR unchanged.
- Reset mid-operation (any state): immediate return to IDLE, all registers to reset values; an in-flight `mem_req` drops asynchronously.

## Timing
- Reset values:
  - state IDLE, PC=`PC_RESET`, AR=0, IR=0, I=0.
  - `mem_req`=0, `ir_valid`=0, `sc_inr`=0, `sc_clr`=1 (IDLE), `fetch_err`=0, `opcode_dec`=8'h01.
- Zero-wait memory (`mem_ack` in the first READ cycle):
  - `start` sampled in cycle 0 -> ADDR in cycle 1, READ in cycle 2, DECODE in cycle 3.
  - `ir_valid` rises in cycle 4.
- Each wait cycle in READ adds exactly one cycle of latency.
- `exec_done` in EXEC cycle k -> ADDR in cycle k+1, so back-to-back instructions cost 3 cycles of fetch overhead each.
- `mem_req` is a registered state decode: high from READ entry until the cycle after `mem_ack`.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A 5-bit wait counter runs in READ and is cleared on entry to READ.
  - If `TIMEOUT_CYCLES` elapse with no `mem_ack`, the block sets `fetch_err` and goes to IDLE; PC and IR are unchanged.
  - `fetch_err` stays set until `clr_n` is asserted.
- `FETCH_TIMEOUT_EN` not defined: READ waits indefinitely; `fetch_err` is tied 0.

## Test plan
- Reset, `PC_RESET`=000; mem[000]=16'h7800, ack same cycle -> `ir_valid` in cycle 4, `opcode_dec`=8'h80, `i_flag`=0, `pc`=001.
- mem[001]=16'hA123, `mem_ack` delayed 3 cycles -> `mem_req` held 4 cycles, `ir_valid` in cycle 7, `i_flag`=1, `opcode_dec`=8'h04, AR=123.
- In EXEC, pulse `exec_done` with `pc_load`=1, `pc_load_val`=0FF -> `sc_clr` high 1 cycle, next `mem_addr`=0FF; `pc_load` without `exec_done` leaves PC unchanged.
- PC=FFF fetch -> PC wraps to 000; `exec_done` with `halt`=1 -> IDLE, `mem_req` stays 0 until `start`.
- `clr_n` low in READ with `mem_req`=1 -> `mem_req`=0 immediately, PC=`PC_RESET`, `ir_valid`=0.
- With `FETCH_TIMEOUT_EN`, no `mem_ack` for 16 cycles -> `fetch_err`=1, state IDLE, IR unchanged.
